// File: rtl/fpaddsub_normalize_stage.sv
// Two-stage normalizer for the FP add/sub datapath: stage 1 captures the raw sum and its
// leading-zero count, stage 2 registers the shifted significand, exponent and flags.
module fpaddsub_normalize_stage #(
  parameter int unsigned MANT_W = 25,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   Sum,
  input  logic              PSgn,
  input  logic              G,
  input  logic              S,
  input  logic [EXP_W-1:0]  Emax,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] NormM,
  output logic [EXP_W-1:0]  NormE,
  output logic              NormG,
  output logic              NormS,
  output logic              Sgn,
  output logic              Zero,
  output logic              Ovf,
  output logic              Unf
);

  localparam int unsigned LzW  = $clog2(MANT_W + 2);
  localparam int unsigned CmpW = ((EXP_W > LzW) ? EXP_W : LzW) + 1;

  logic              s1_valid_q, s1_valid_d;
  logic [MANT_W:0]   sum_q, sum_d;
  logic              sgn1_q, sgn1_d, g1_q, g1_d, s1_q, s1_d, carry_q, carry_d;
  logic [EXP_W-1:0]  emax_q, emax_d;
  logic [LzW-1:0]    lz_q, lz_d;

  logic              out_valid_q, out_valid_d;
  logic [MANT_W-1:0] norm_m_q, norm_m_d;
  logic [EXP_W-1:0]  norm_e_q, norm_e_d;
  logic              norm_g_q, norm_g_d, norm_s_q, norm_s_d;
  logic              sgn_q, sgn_d, zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

  logic              advance;
  logic [MANT_W:0]   frac_in, frac_s1, shifted;
  logic [EXP_W-1:0]  e_inc;
  logic              found;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign frac_in  = {Sum[MANT_W-1:0], G};

  // Leading-zero count of {Sum[MANT_W-1:0], G}, saturating at MANT_W+1 when all zero.
  always_comb begin
    lz_d  = LzW'(MANT_W + 1);
    found = 1'b0;
    for (int i = int'(MANT_W); i >= 0; i--) begin
      if (!found && frac_in[i]) begin
        lz_d  = LzW'(int'(MANT_W) - i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    sum_d      = sum_q;
    sgn1_d     = sgn1_q;
    g1_d       = g1_q;
    s1_d       = s1_q;
    emax_d     = emax_q;
    carry_d    = carry_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        sum_d   = Sum;
        sgn1_d  = PSgn;
        g1_d    = G;
        s1_d    = S;
        emax_d  = Emax;
        carry_d = Sum[MANT_W];
      end
    end
  end

  assign frac_s1 = {sum_q[MANT_W-1:0], g1_q};
  assign shifted = frac_s1 << lz_q;
  assign e_inc   = emax_q + EXP_W'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    norm_m_d    = norm_m_q;
    norm_e_d    = norm_e_q;
    norm_g_d    = norm_g_q;
    norm_s_d    = norm_s_q;
    sgn_d       = sgn_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        norm_m_d = '0;
        norm_e_d = '0;
        norm_g_d = 1'b0;
        norm_s_d = 1'b0;
        sgn_d    = sgn1_q;
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (carry_q) begin
          if (e_inc == '1) begin
            ovf_d    = 1'b1;
            norm_e_d = '1;
          end else begin
            norm_m_d = sum_q[MANT_W:1];
            norm_g_d = sum_q[0];
            norm_s_d = g1_q | s1_q;
            norm_e_d = e_inc;
          end
        end else if (frac_s1 == '0) begin
          zero_d   = 1'b1;
          norm_s_d = s1_q;
        end else if (lz_q == '0) begin
          norm_m_d = sum_q[MANT_W-1:0];
          norm_g_d = g1_q;
          norm_s_d = s1_q;
          norm_e_d = emax_q;
        end else if (CmpW'(lz_q) < CmpW'(emax_q)) begin
          norm_m_d = shifted[MANT_W:1];
          norm_g_d = shifted[0];
          norm_s_d = s1_q;
          norm_e_d = emax_q - EXP_W'(lz_q);
        end else begin
          // Shift would drive the exponent to zero or below: flush.
          unf_d  = 1'b1;
          zero_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      sgn1_q      <= 1'b0;
      g1_q        <= 1'b0;
      s1_q        <= 1'b0;
      emax_q      <= '0;
      carry_q     <= 1'b0;
      lz_q        <= '0;
      out_valid_q <= 1'b0;
      norm_m_q    <= '0;
      norm_e_q    <= '0;
      norm_g_q    <= 1'b0;
      norm_s_q    <= 1'b0;
      sgn_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      sum_q       <= sum_d;
      sgn1_q      <= sgn1_d;
      g1_q        <= g1_d;
      s1_q        <= s1_d;
      emax_q      <= emax_d;
      carry_q     <= carry_d;
      if (in_ready && in_valid) lz_q <= lz_d;
      out_valid_q <= out_valid_d;
      norm_m_q    <= norm_m_d;
      norm_e_q    <= norm_e_d;
      norm_g_q    <= norm_g_d;
      norm_s_q    <= norm_s_d;
      sgn_q       <= sgn_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign NormM     = norm_m_q;
  assign NormE     = norm_e_q;
  assign NormG     = norm_g_q;
  assign NormS     = norm_s_q;
  assign Sgn       = sgn_q;
  assign Zero      = zero_q;
  assign Ovf       = ovf_q;
  assign Unf       = unf_q;

endmodule

// File: doc/fpaddsub_normalize_stage.md
Name: fpaddsub_normalize_stage

Overview:
Pipelined normalization stage that sits directly downstream of the FP add/sub execute stage. It consumes the raw 26-bit significand sum (carry bit included), result sign, guard/sticky bits and the larger operand exponent. It produces a normalized significand with the hidden bit at MSB, an adjusted exponent, and zero/overflow/underflow flags for the rounding stage. Two register stages, with a valid/ready handshake and full backpressure.

Parameters:
MANT_W, 25, significand width incl. hidden bit (execute stage Mmax/Mmin width); Sum is MANT_W+1 bits
EXP_W, 8, exponent width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream presents a valid result
in_ready  out  1  stage can accept this cycle
Sum  in  MANT_W+1  raw sum from execute stage; bit MANT_W = carry-out
PSgn  in  1  result sign from execute stage
G  in  1  guard bit below Sum LSB
S  in  1  sticky bit below G
Emax  in  EXP_W  exponent of larger operand
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
NormM  out  MANT_W  normalized significand, bit MANT_W-1 = hidden bit
NormE  out  EXP_W  adjusted exponent
NormG  out  1  guard after normalization
NormS  out  1  sticky after normalization
Sgn  out  1  result sign
Zero  out  1  result is exactly zero
Ovf  out  1  exponent overflow
Unf  out  1  exponent underflow (flushed to zero)

Behaviour:
- Reset: out_valid=0, internal stage-1 valid=0, in_ready=1 in the cycle after rst deasserts; NormM, NormE, NormG, NormS, Sgn, Zero, Ovf, Unf all 0. In-flight data is dropped when rst asserts mid-operation.
- Transfer: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Pipeline: stage 1 (S1) registers the inputs plus carry = Sum[MANT_W] and LZ = leading-zero count of {Sum[MANT_W-1:0],G}, saturated at MANT_W+1. Stage 2 (S2) registers the shifted result and flags.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle.
- Advance rules: S2 loads when !out_valid || out_ready. S1 advances into S2 under the same condition. in_ready = !s1_valid || (!out_valid || out_ready). Combinational ready path only; no bubbles are inserted when the pipeline is full and draining.
- Stalled registers hold their values unchanged. No loss, no duplication, order preserved.
- Carry case (Sum[MANT_W]=1):
  - NormM = Sum[MANT_W:1]; NormG = Sum[0]; NormS = G|S; NormE = Emax+1.
  - If Emax+1 == all-ones: Ovf=1, NormE = all-ones, NormM=0, NormG=0, NormS=0.
- No-carry case, LZ=0: pass through; NormE = Emax; NormG = G; NormS = S.
- No-carry case, 0 < LZ < Emax:
  - {NormM,NormG} = {Sum[MANT_W-1:0],G} << LZ, zero-filled.
  - NormS = S; NormE = Emax-LZ.
- Zero: if Sum==0 and G==0, then Zero=1, NormE=0, NormM=0, NormG=0, NormS=S. Ovf and Unf stay 0.
- Underflow: nonzero result with LZ >= Emax gives Unf=1, Zero=1, NormE=0, NormM=0, NormG=0, NormS=0 (flush to zero).
- Sign: Sgn = PSgn in all cases, including zero and underflow.
- Flags are mutually exclusive except Unf implies Zero.

Test Plan:
- Sum=26'h1800000, Emax=127, G=0, S=0, out_ready=1 -> 2 cycles later out_valid=1, NormM=25'h1800000, NormE=127, all flags 0.
- Sum=26'h2000001, Emax=127, G=1 -> NormM=25'h1000000, NormE=128, NormG=1, NormS=1; repeat with Emax=254 -> Ovf=1, NormE=255, NormM=0.
- Sum=26'h0800000, Emax=127 (subtract result) -> NormM=25'h1000000, NormE=126; Sum=26'h0000000, G=1, Emax=127 -> LZ=25, NormM=25'h1000000, NormE=102, NormG=0.
- Sum=0, G=0, PSgn=1 -> Zero=1, Sgn=1, NormE=0; Sum=26'h0000001, Emax=5 -> Unf=1, Zero=1, NormM=0.
- Backpressure: out_ready=0, in_valid=1 for 4 cycles with distinct Sum -> exactly 2 accepted, in_ready=0 thereafter; release out_ready -> results emerge in order with no duplicates, one per cycle.
- rst asserted for 1 cycle with both stages full -> next cycle out_valid=0, all outputs 0, in_ready=1; fresh input emerges after 2 cycles.
